// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential FIR filter issuing one tap per clock to an external pipelined multiplier.
// Optional macro FIR_MAC_SAT_EN: saturate out_data on accumulator overflow instead of wrapping.
module fir_mac_seq #(
  parameter int TAPS        = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  input  logic [23:0]             s_data,
  output logic                    s_ready,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [34:0]             coef_data,
  output logic [23:0]             mul_a,
  output logic [34:0]             mul_b,
  input  logic [58:0]             mul_m,
  output logic                    out_valid,
  output logic [23:0]             out_data
);

  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = 59 + AW;
  localparam int VLD_W = 1 + MUL_LATENCY;
  localparam logic [VLD_W-1:0] LAST_ONLY = VLD_W'(1) << MUL_LATENCY;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [AW-1:0]           tap_q, tap_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_addr;
  logic [23:0]             samp_q;
  logic [VLD_W-1:0]        vld_q, vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [23:0]             out_data_q, out_data_d;
  logic [23:0]             result;
  logic [23:0]             dl_q [TAPS];
  logic                    accept;

  assign accept  = s_valid && ready_q;
  assign rd_addr = wr_ptr_q - tap_q;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_dl
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dl_q[gi] <= '0;
      end else if (accept && (wr_ptr_q == AW'(gi))) begin
        dl_q[gi] <= s_data;
      end
    end
  end

  // Sample read is registered so it lines up with the one-cycle coefficient ROM latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp_q <= '0;
    end else begin
      samp_q <= dl_q[rd_addr];
    end
  end

`ifdef FIR_MAC_SAT_EN
  always_comb begin
    result = acc_q[57:34];
    if (!((&acc_q[ACC_W-1:57]) || !(|acc_q[ACC_W-1:57]))) begin
      result = acc_q[ACC_W-1] ? 24'h800000 : 24'h7FFFFF;
    end
  end
`else
  always_comb begin
    result = acc_q[57:34];
  end
`endif

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    vld_d       = (vld_q << 1) | VLD_W'(state_q == ISSUE);
    acc_d       = acc_q;
    if (vld_q[MUL_LATENCY]) begin
      acc_d = acc_q + {{(ACC_W-59){mul_m[58]}}, mul_m};
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '0;
          tap_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tap_d = tap_q + 1'b1;
        if (tap_q == AW'(TAPS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Only the final tap is left in flight: it is summed on this edge.
        if (vld_q == LAST_ONLY) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = result;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      tap_q       <= '0;
      wr_ptr_q    <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      tap_q       <= tap_d;
      wr_ptr_q    <= wr_ptr_d;
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s_ready   = ready_q;
  assign coef_addr = tap_q;
  assign mul_a     = vld_q[0] ? samp_q : 24'h0;
  assign mul_b     = vld_q[0] ? coef_data : 35'h0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
